// File: rtl/write_pkg.sv
// Shared types and helpers for the output-BRAM write path: FSM states,
// packing geometry and the fill-count-to-byte-mask conversion.
`default_nettype none

package write_pkg;

    localparam int WORD_BITS       = 32;
    localparam int PIXEL_BITS      = 8;
    localparam int PIXELS_PER_WORD = WORD_BITS / PIXEL_BITS;
    localparam int FILL_W          = $clog2(PIXELS_PER_WORD + 1);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_DONE    = 1'b1
    } state_t;

    // Lane i is enabled when fewer than fill pixels precede it.
    function automatic logic [PIXELS_PER_WORD-1:0] fill_to_mask(input logic [FILL_W-1:0] fill);
        logic [PIXELS_PER_WORD-1:0] mask;
        mask = '0;
        for (int i = 0; i < PIXELS_PER_WORD; i++) begin
            mask[i] = (FILL_W'(i) < fill);
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/write_module_pixel_packer.sv
// Lane register and fill counter. word/fill/full describe the packed state
// including the pixel being sampled this cycle, so the caller can write on the same edge.
`default_nettype none

module pixel_packer
    import write_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PIXEL_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIXEL_SIZE-1:0] pixel,
    input  logic                  pixel_valid,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] word,
    output logic [FILL_W-1:0]     fill,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] lanes;
    logic [FILL_W-1:0]     count;

    always_comb begin
        word = lanes;
        fill = count;
        if (pixel_valid) begin
            for (int i = 0; i < PIXELS_PER_WORD; i++) begin
                if (count == FILL_W'(i)) begin
                    word[i*PIXEL_SIZE +: PIXEL_SIZE] = pixel;
                end
            end
            fill = count + FILL_W'(1);
        end
        full = (fill == FILL_W'(PIXELS_PER_WORD));
    end

    // Clearing after every completed or flushed word keeps unfilled lanes at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes <= '0;
            count <= '0;
        end else if (clear || full) begin
            lanes <= '0;
            count <= '0;
        end else begin
            lanes <= word;
            count <= fill;
        end
    end

endmodule

`default_nettype wire

// File: rtl/write_module.sv
// Packs result pixels into words and writes them to the output BRAM from OUTPUT_ADDR.
// Optional PARTIAL_FLUSH_EN: flush a partial word on conv_done instead of discarding it.
`default_nettype none

module write_module
    import write_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_ADDR = 32'hA000_0000,
    parameter int                    PIXEL_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_data,
    output logic [3:0]            write_enable,
    input  logic [PIXEL_SIZE-1:0] pixel,
    input  logic                  pixel_valid,
    input  logic                  conv_done
);

    localparam int IDX_W = ADDR_WIDTH - 2;

`ifdef PARTIAL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    state_t                state;
    logic [IDX_W-1:0]      word_index;
    logic [DATA_WIDTH-1:0] packed_word;
    logic [FILL_W-1:0]     packed_fill;
    logic                  packed_full;
    logic                  flush_evt;
    logic [ADDR_WIDTH-1:0] word_addr;

    // conv_done only acts on the edge where the FSM is still collecting.
    assign flush_evt = (state == S_COLLECT) && conv_done;
    assign word_addr = OUTPUT_ADDR + {word_index, 2'b00};

    pixel_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PIXEL_SIZE (PIXEL_SIZE)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .clear       (flush_evt),
        .word        (packed_word),
        .fill        (packed_fill),
        .full        (packed_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_COLLECT;
            word_index   <= '0;
            bram_addr    <= OUTPUT_ADDR;
            bram_data    <= '0;
            write_enable <= '0;
        end else begin
            write_enable <= '0;

            case (state)
                S_COLLECT: if (conv_done)  state <= S_DONE;
                S_DONE:    if (!conv_done) state <= S_COLLECT;
                default:   state <= S_COLLECT;
            endcase

            if (packed_full) begin
                bram_data    <= packed_word;
                bram_addr    <= word_addr;
                write_enable <= '1;
                word_index   <= flush_evt ? '0 : word_index + IDX_W'(1);
            end else if (flush_evt) begin
                if (FLUSH_EN && (packed_fill != '0)) begin
                    bram_data    <= packed_word;
                    bram_addr    <= word_addr;
                    write_enable <= fill_to_mask(packed_fill);
                end
                word_index <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_write_module.sv
// Scoreboard bench for write_module: a reference packer queues expected writes,
// a negedge monitor pops and compares every observed write.
`default_nettype none

module tb_write_module;

    localparam logic [31:0] BASE = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bram_addr;
    logic [31:0] bram_data;
    logic [3:0]  write_enable;
    logic [7:0]  pixel;
    logic        pixel_valid;
    logic        conv_done;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    logic [31:0] m_word;
    int          m_fill;
    logic [29:0] m_idx;
    bit          m_done;

    always #5 clk = ~clk;

    write_module dut (
        .clk          (clk),
        .reset        (reset),
        .bram_addr    (bram_addr),
        .bram_data    (bram_data),
        .write_enable (write_enable),
        .pixel        (pixel),
        .pixel_valid  (pixel_valid),
        .conv_done    (conv_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (reset === 1'b1 && write_enable !== 4'h0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_we", {28'h0, write_enable}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bram_addr, e.addr);
                check("write_data", bram_data, e.data);
                check("write_we", {28'h0, write_enable}, {28'h0, e.we});
            end
        end
    end

    task automatic model_clear();
        m_word = '0;
        m_fill = 0;
        m_idx  = '0;
        m_done = 1'b0;
    endtask

    task automatic drive(input logic [7:0] p, input logic v, input logic d);
        bit  full;
        wr_t w;
        @(posedge clk);
        #1;
        pixel       = p;
        pixel_valid = v;
        conv_done   = d;
        full = 1'b0;
        if (v) begin
            m_word[8*m_fill +: 8] = p;
            m_fill++;
            if (m_fill == 4) begin
                w.addr = BASE + {m_idx, 2'b00};
                w.data = m_word;
                w.we   = 4'hF;
                exp_q.push_back(w);
                m_idx++;
                m_word = '0;
                m_fill = 0;
                full   = 1'b1;
            end
        end
        if (d && !m_done) begin
`ifdef PARTIAL_FLUSH_EN
            if (!full && m_fill != 0) begin
                w.addr = BASE + {m_idx, 2'b00};
                w.data = m_word;
                w.we   = 4'((5'd1 << m_fill) - 5'd1);
                exp_q.push_back(w);
            end
`endif
            m_idx  = '0;
            m_word = '0;
            m_fill = 0;
        end
        m_done = d;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        pixel_valid = 1'b0;
        conv_done   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", {28'h0, write_enable}, 32'h0);
        check("rst_addr", bram_addr, BASE);
        check("rst_data", bram_data, 32'h0);
        reset = 1'b1;
    endtask

    task automatic send_valid(input logic [7:0] p);
        drive(p, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] t2 [8];
        logic [7:0] t3 [12];
        t2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        t3 = '{8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h44, 8'h55, 8'h66,
               8'h77, 8'h88, 8'h99, 8'hAA};
        reset       = 1'b1;
        pixel       = '0;
        pixel_valid = 1'b0;
        conv_done   = 1'b0;
        model_clear();
        #2;
        do_reset();

        // Two back-to-back full words, then idle hold
        foreach (t2[i]) send_valid(t2[i]);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        check("idle_hold_addr", bram_addr, 32'hA000_0004);
        check("idle_hold_data", bram_data, 32'h8877_6655);

        // Invalid pixels dropped, then continuous words and conv_done with nothing pending
        drive(8'h99, 1'b0, 1'b0);
        drive(8'hAA, 1'b0, 1'b0);
        drive(8'hBB, 1'b0, 1'b0);
        foreach (t3[i]) send_valid(t3[i]);
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0);

        // Partial word then conv_done; next image restarts at the base address
        do_reset();
        send_valid(8'h01);
        send_valid(8'h02);
        send_valid(8'h03);
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        send_valid(8'h10);
        send_valid(8'h20);
        send_valid(8'h30);
        send_valid(8'h40);

        // Pixel completing a word together with conv_done: full write only, index resets
        send_valid(8'h50);
        send_valid(8'h60);
        send_valid(8'h70);
        drive(8'h80, 1'b1, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h5A, 1'b1, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        send_valid(8'hA1);
        send_valid(8'hA2);
        send_valid(8'hA3);
        send_valid(8'hA4);
        drive(8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-word
        send_valid(8'hC1);
        send_valid(8'hC2);
        @(posedge clk);
        #3;
        reset       = 1'b0;
        pixel_valid = 1'b0;
        model_clear();
        #1;
        check("async_rst_we", {28'h0, write_enable}, 32'h0);
        check("async_rst_addr", bram_addr, BASE);
        check("async_rst_data", bram_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) drive(8'h00, 1'b0, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
